// File: rtl/ahb_mem_arbiter_if.sv
// Bundle of both requester ports and the shared AHB-Lite manager bus.
// The master modport is the arbiter side; slave is the pipeline/subordinate side.
interface ahb_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  m0_req_valid;
    logic                  m0_req_write;
    logic [ADDR_WIDTH-1:0] m0_req_addr;
    logic [DATA_WIDTH-1:0] m0_req_wdata;
    logic [2:0]            m0_req_size;
    logic                  m0_req_unsign;
    logic                  m0_req_ready;
    logic                  m0_resp_valid;
    logic [DATA_WIDTH-1:0] m0_resp_rdata;
    logic                  m0_resp_err;

    logic                  m1_req_valid;
    logic                  m1_req_write;
    logic [ADDR_WIDTH-1:0] m1_req_addr;
    logic [DATA_WIDTH-1:0] m1_req_wdata;
    logic [2:0]            m1_req_size;
    logic                  m1_req_unsign;
    logic                  m1_req_ready;
    logic                  m1_resp_valid;
    logic [DATA_WIDTH-1:0] m1_resp_rdata;
    logic                  m1_resp_err;

    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADY;
    logic                  HRESP;
    logic                  sub_unsign_o;

    modport master (
        input  m0_req_valid, m0_req_write, m0_req_addr, m0_req_wdata, m0_req_size, m0_req_unsign,
        output m0_req_ready, m0_resp_valid, m0_resp_rdata, m0_resp_err,
        input  m1_req_valid, m1_req_write, m1_req_addr, m1_req_wdata, m1_req_size, m1_req_unsign,
        output m1_req_ready, m1_resp_valid, m1_resp_rdata, m1_resp_err,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, sub_unsign_o,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        output m0_req_valid, m0_req_write, m0_req_addr, m0_req_wdata, m0_req_size, m0_req_unsign,
        input  m0_req_ready, m0_resp_valid, m0_resp_rdata, m0_resp_err,
        output m1_req_valid, m1_req_write, m1_req_addr, m1_req_wdata, m1_req_size, m1_req_unsign,
        input  m1_req_ready, m1_resp_valid, m1_resp_rdata, m1_resp_err,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, sub_unsign_o,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_mem_arbiter.sv
// Two-requester AHB-Lite arbiter: grants one single transfer at a time,
// sequences address/data phases, and returns a registered response.
module ahb_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ahb_mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ERR1} state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_e                state_q, state_d;
    logic                  last_q, last_d;     // 1: m1 won the most recent grant
    logic                  owner_q, owner_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            htrans_q, htrans_d;
    logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
    logic                  hwrite_q, hwrite_d;
    logic [2:0]            hsize_q, hsize_d;
    logic [3:0]            hprot_q, hprot_d;
    logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
    logic                  sub_unsign_q, sub_unsign_d;
    logic [1:0]            resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;

    logic                  grant0, grant1, grant_any, misaligned;
    logic                  sel_write, sel_unsign;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [2:0]            sel_size;

    // Ready is combinational; it is held low while reset is asserted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if ((state_q == ST_IDLE) && !rst_i) begin
            grant0 = bus.m0_req_valid && (!bus.m1_req_valid || FIXED_PRIO || last_q);
            grant1 = bus.m1_req_valid && !grant0;
        end
        grant_any  = grant0 || grant1;
        sel_write  = grant1 ? bus.m1_req_write  : bus.m0_req_write;
        sel_addr   = grant1 ? bus.m1_req_addr   : bus.m0_req_addr;
        sel_wdata  = grant1 ? bus.m1_req_wdata  : bus.m0_req_wdata;
        sel_size   = grant1 ? bus.m1_req_size   : bus.m0_req_size;
        sel_unsign = grant1 ? bus.m1_req_unsign : bus.m0_req_unsign;
        misaligned = ((sel_size == 3'd1) && sel_addr[0]) ||
                     ((sel_size == 3'd2) && (sel_addr[1:0] != 2'b00));
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        owner_d      = owner_q;
        wdata_d      = wdata_q;
        htrans_d     = htrans_q;
        haddr_d      = haddr_q;
        hwrite_d     = hwrite_q;
        hsize_d      = hsize_q;
        hprot_d      = hprot_q;
        hwdata_d     = hwdata_q;
        sub_unsign_d = sub_unsign_q;
        resp_valid_d = '0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    last_d  = grant1;
                    owner_d = grant1;
                    wdata_d = sel_wdata;
                    if (misaligned) begin
                        // Rejected without touching the bus; error returns next cycle.
                        resp_valid_d[grant1] = 1'b1;
                        resp_rdata_d         = '0;
                        resp_err_d           = 1'b1;
                    end else begin
                        state_d      = ST_ADDR;
                        htrans_d     = HTRANS_NONSEQ;
                        haddr_d      = sel_addr;
                        hwrite_d     = sel_write;
                        hsize_d      = sel_size;
                        hprot_d      = grant1 ? 4'b0010 : 4'b0011;
                        sub_unsign_d = sel_unsign;
                    end
                end
            end
            ST_ADDR: begin
                if (bus.HREADY) begin
                    state_d  = ST_DATA;
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = wdata_q;
                end
            end
            ST_DATA: begin
                if (bus.HRESP) begin
                    if (bus.HREADY) begin
                        state_d               = ST_IDLE;
                        sub_unsign_d          = 1'b0;
                        resp_valid_d[owner_q] = 1'b1;
                        resp_rdata_d          = '0;
                        resp_err_d            = 1'b1;
                    end else begin
                        state_d = ST_ERR1;
                    end
                end else if (bus.HREADY) begin
                    state_d               = ST_IDLE;
                    sub_unsign_d          = 1'b0;
                    resp_valid_d[owner_q] = 1'b1;
                    resp_rdata_d          = hwrite_q ? '0 : bus.HRDATA;
                    resp_err_d            = 1'b0;
                end
            end
            ST_ERR1: begin
                if (bus.HREADY) begin
                    state_d               = ST_IDLE;
                    sub_unsign_d          = 1'b0;
                    resp_valid_d[owner_q] = 1'b1;
                    resp_rdata_d          = '0;
                    resp_err_d            = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            wdata_q      <= '0;
            htrans_q     <= HTRANS_IDLE;
            haddr_q      <= '0;
            hwrite_q     <= 1'b0;
            hsize_q      <= '0;
            hprot_q      <= '0;
            hwdata_q     <= '0;
            sub_unsign_q <= 1'b0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            wdata_q      <= wdata_d;
            htrans_q     <= htrans_d;
            haddr_q      <= haddr_d;
            hwrite_q     <= hwrite_d;
            hsize_q      <= hsize_d;
            hprot_q      <= hprot_d;
            hwdata_q     <= hwdata_d;
            sub_unsign_q <= sub_unsign_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.m0_req_ready  = grant0;
    assign bus.m1_req_ready  = grant1;
    assign bus.m0_resp_valid = resp_valid_q[0];
    assign bus.m1_resp_valid = resp_valid_q[1];
    assign bus.m0_resp_rdata = resp_rdata_q;
    assign bus.m1_resp_rdata = resp_rdata_q;
    assign bus.m0_resp_err   = resp_err_q;
    assign bus.m1_resp_err   = resp_err_q;
    assign bus.HTRANS        = htrans_q;
    assign bus.HADDR         = haddr_q;
    assign bus.HWRITE        = hwrite_q;
    assign bus.HSIZE         = hsize_q;
    assign bus.HBURST        = 3'b000;
    assign bus.HPROT         = hprot_q;
    assign bus.HWDATA        = hwdata_q;
    assign bus.sub_unsign_o  = sub_unsign_q;
endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Scoreboarded bench for ahb_mem_arbiter: a round-robin and a fixed-priority
// instance share the same stimulus; sel picks which one is observed.
module tb_ahb_mem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    logic sel;
    always #5 clk = ~clk;

    ahb_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_rr ();
    ahb_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_fx ();

    ahb_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1'b0)) u_rr (
        .clk_i(clk), .rst_i(rst), .bus(bus_rr));
    ahb_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1'b1)) u_fx (
        .clk_i(clk), .rst_i(rst), .bus(bus_fx));

    assign bus_fx.m0_req_valid  = bus_rr.m0_req_valid;
    assign bus_fx.m0_req_write  = bus_rr.m0_req_write;
    assign bus_fx.m0_req_addr   = bus_rr.m0_req_addr;
    assign bus_fx.m0_req_wdata  = bus_rr.m0_req_wdata;
    assign bus_fx.m0_req_size   = bus_rr.m0_req_size;
    assign bus_fx.m0_req_unsign = bus_rr.m0_req_unsign;
    assign bus_fx.m1_req_valid  = bus_rr.m1_req_valid;
    assign bus_fx.m1_req_write  = bus_rr.m1_req_write;
    assign bus_fx.m1_req_addr   = bus_rr.m1_req_addr;
    assign bus_fx.m1_req_wdata  = bus_rr.m1_req_wdata;
    assign bus_fx.m1_req_size   = bus_rr.m1_req_size;
    assign bus_fx.m1_req_unsign = bus_rr.m1_req_unsign;
    assign bus_fx.HRDATA        = bus_rr.HRDATA;
    assign bus_fx.HREADY        = bus_rr.HREADY;
    assign bus_fx.HRESP         = bus_rr.HRESP;

    logic          o_r0, o_r1, o_v0, o_v1, o_e0, o_e1, o_uns, o_hwrite;
    logic [1:0]    o_htrans;
    logic [2:0]    o_hsize, o_hburst;
    logic [3:0]    o_hprot;
    logic [DW-1:0] o_rd0, o_rd1, o_hwdata;
    logic [AW-1:0] o_haddr;

    assign o_r0     = sel ? bus_fx.m0_req_ready  : bus_rr.m0_req_ready;
    assign o_r1     = sel ? bus_fx.m1_req_ready  : bus_rr.m1_req_ready;
    assign o_v0     = sel ? bus_fx.m0_resp_valid : bus_rr.m0_resp_valid;
    assign o_v1     = sel ? bus_fx.m1_resp_valid : bus_rr.m1_resp_valid;
    assign o_e0     = sel ? bus_fx.m0_resp_err   : bus_rr.m0_resp_err;
    assign o_e1     = sel ? bus_fx.m1_resp_err   : bus_rr.m1_resp_err;
    assign o_rd0    = sel ? bus_fx.m0_resp_rdata : bus_rr.m0_resp_rdata;
    assign o_rd1    = sel ? bus_fx.m1_resp_rdata : bus_rr.m1_resp_rdata;
    assign o_uns    = sel ? bus_fx.sub_unsign_o  : bus_rr.sub_unsign_o;
    assign o_hwrite = sel ? bus_fx.HWRITE        : bus_rr.HWRITE;
    assign o_htrans = sel ? bus_fx.HTRANS        : bus_rr.HTRANS;
    assign o_hsize  = sel ? bus_fx.HSIZE         : bus_rr.HSIZE;
    assign o_hburst = sel ? bus_fx.HBURST        : bus_rr.HBURST;
    assign o_hprot  = sel ? bus_fx.HPROT         : bus_rr.HPROT;
    assign o_hwdata = sel ? bus_fx.HWDATA        : bus_rr.HWDATA;
    assign o_haddr  = sel ? bus_fx.HADDR         : bus_rr.HADDR;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   nonseq_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic id, input logic [DW-1:0] rdata, input logic err);
        exp_t e;
        e.id = id;
        e.rdata = rdata;
        e.err = err;
        sb.push_back(e);
    endtask

    task automatic pop_resp(input logic id, input logic [DW-1:0] rd, input logic err);
        exp_t e;
        if (sb.size() == 0) begin
            check("resp_unexpected_id", 64'(id), 64'd2);
        end else begin
            e = sb.pop_front();
            check("resp_id", 64'(id), 64'(e.id));
            check("resp_rdata", 64'(rd), 64'(e.rdata));
            check("resp_err", 64'(err), 64'(e.err));
        end
    endtask

    // Observes one cycle's registered outputs at the falling edge.
    task automatic mon();
        if (!rst) begin
            if (o_htrans == 2'b10) nonseq_cnt++;
            if (o_v0) pop_resp(1'b0, o_rd0, o_e0);
            if (o_v1) pop_resp(1'b1, o_rd1, o_e1);
        end
    endtask

    task automatic step();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int m, input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [2:0] s, input logic u);
        if (m == 0) begin
            bus_rr.m0_req_valid = v;  bus_rr.m0_req_write = w; bus_rr.m0_req_addr = a;
            bus_rr.m0_req_wdata = d;  bus_rr.m0_req_size  = s; bus_rr.m0_req_unsign = u;
        end else begin
            bus_rr.m1_req_valid = v;  bus_rr.m1_req_write = w; bus_rr.m1_req_addr = a;
            bus_rr.m1_req_wdata = d;  bus_rr.m1_req_size  = s; bus_rr.m1_req_unsign = u;
        end
    endtask

    task automatic wait_grant(output int g);
        g = -1;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (o_r0) begin g = 0; break; end
            if (o_r1) begin g = 1; break; end
            step();
        end
        if (g < 0) check("grant_timeout", 64'(o_r0 | o_r1), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) step();
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req(0, 1'b0, 1'b0, '0, '0, 3'd0, 1'b0);
        req(1, 1'b0, 1'b0, '0, '0, 3'd0, 1'b0);
        bus_rr.HREADY = 1'b1;
        bus_rr.HRESP  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_htrans"}, 64'(o_htrans), 64'd0);
        check({tag, "_haddr"},  64'(o_haddr),  64'd0);
        check({tag, "_hwrite"}, 64'(o_hwrite), 64'd0);
        check({tag, "_hsize"},  64'(o_hsize),  64'd0);
        check({tag, "_hburst"}, 64'(o_hburst), 64'd0);
        check({tag, "_hprot"},  64'(o_hprot),  64'd0);
        check({tag, "_hwdata"}, 64'(o_hwdata), 64'd0);
        check({tag, "_ready"},  64'({o_r0, o_r1}), 64'd0);
        check({tag, "_rvalid"}, 64'({o_v0, o_v1}), 64'd0);
        check({tag, "_rdata"},  64'(o_rd0), 64'd0);
        check({tag, "_err"},    64'({o_e0, o_e1}), 64'd0);
        check({tag, "_unsign"}, 64'(o_uns), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int g;
        int ns0;
        rst = 1'b1;
        sel = 1'b0;
        bus_rr.HRDATA = '0;
        bus_rr.HREADY = 1'b1;
        bus_rr.HRESP  = 1'b0;
        req(1, 1'b0, 1'b0, '0, '0, 3'd0, 1'b0);
        req(0, 1'b1, 1'b0, 32'h100, '0, 3'd2, 1'b0);
        step();
        #1;
        check_reset_outputs("rst");
        req(0, 1'b0, 1'b0, '0, '0, 3'd0, 1'b0);
        step();
        rst = 1'b0;
        step();

        // Zero-wait m0 word read
        bus_rr.HRDATA = 32'hDEAD_BEEF;
        req(0, 1'b1, 1'b0, 32'h100, '0, 3'd2, 1'b0);
        wait_grant(g);
        check("t1_grant", 64'(g), 64'd0);
        push_exp(1'b0, 32'hDEAD_BEEF, 1'b0);
        step();
        req(0, 1'b0, 1'b0, '0, '0, 3'd0, 1'b0);
        #1;
        check("t1_htrans_a", 64'(o_htrans), 64'd2);
        check("t1_haddr", 64'(o_haddr), 64'h100);
        check("t1_hprot", 64'(o_hprot), 64'b0011);
        check("t1_hsize", 64'(o_hsize), 64'd2);
        check("t1_hwrite", 64'(o_hwrite), 64'd0);
        step();
        check("t1_htrans_d", 64'(o_htrans), 64'd0);
        step();
        check("t1_rvalid_t3", 64'(o_v0), 64'd1);
        step();

        // m1 write with two data-phase wait states
        req(1, 1'b1, 1'b1, 32'h200, 32'h1234_5678, 3'd2, 1'b0);
        wait_grant(g);
        check("t2_grant", 64'(g), 64'd1);
        push_exp(1'b1, '0, 1'b0);
        step();
        req(1, 1'b0, 1'b0, '0, '0, 3'd0, 1'b0);
        #1;
        check("t2_htrans_a", 64'(o_htrans), 64'd2);
        check("t2_hwrite", 64'(o_hwrite), 64'd1);
        check("t2_haddr", 64'(o_haddr), 64'h200);
        check("t2_hprot", 64'(o_hprot), 64'b0010);
        step();
        bus_rr.HREADY = 1'b0;
        check("t2_htrans_d", 64'(o_htrans), 64'd0);
        check("t2_hwdata0", 64'(o_hwdata), 64'h1234_5678);
        step();
        check("t2_hwdata1", 64'(o_hwdata), 64'h1234_5678);
        check("t2_no_early_resp", 64'(o_v1), 64'd0);
        step();
        bus_rr.HREADY = 1'b1;
        check("t2_hwdata2", 64'(o_hwdata), 64'h1234_5678);
        step();
        check("t2_rvalid_t5", 64'(o_v1), 64'd1);
        step();

        // Round-robin contention
        bus_rr.HRDATA = 32'h5A5A_1234;
        req(0, 1'b1, 1'b0, 32'h1000, '0, 3'd2, 1'b0);
        req(1, 1'b1, 1'b0, 32'h2000, '0, 3'd2, 1'b1);
        for (int k = 0; k < 4; k++) begin
            wait_grant(g);
            check("rr_grant", 64'(g), 64'(k % 2));
            push_exp(1'((k % 2) != 0), 32'h5A5A_1234, 1'b0);
            step();
        end
        req(0, 1'b0, 1'b0, '0, '0, 3'd0, 1'b0);
        req(1, 1'b0, 1'b0, '0, '0, 3'd0, 1'b0);
        drain();

        // Fixed priority: m0 wins while valid, then m1
        sel = 1'b1;
        do_reset();
        bus_rr.HRDATA = 32'h0F0F_5555;
        req(0, 1'b1, 1'b0, 32'h1004, '0, 3'd2, 1'b0);
        req(1, 1'b1, 1'b0, 32'h2004, '0, 3'd2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            wait_grant(g);
            check("fx_grant", 64'(g), 64'd0);
            push_exp(1'b0, 32'h0F0F_5555, 1'b0);
            step();
        end
        req(0, 1'b0, 1'b0, '0, '0, 3'd0, 1'b0);
        wait_grant(g);
        check("fx_grant_m1", 64'(g), 64'd1);
        push_exp(1'b1, 32'h0F0F_5555, 1'b0);
        step();
        req(1, 1'b0, 1'b0, '0, '0, 3'd0, 1'b0);
        drain();

        // Two-cycle ERROR response on an m0 read
        sel = 1'b0;
        do_reset();
        bus_rr.HRDATA = 32'hFFFF_FFFF;
        req(0, 1'b1, 1'b0, 32'h300, '0, 3'd2, 1'b0);
        wait_grant(g);
        check("t4_grant", 64'(g), 64'd0);
        push_exp(1'b0, '0, 1'b1);
        step();
        req(0, 1'b0, 1'b0, '0, '0, 3'd0, 1'b0);
        #1;
        check("t4_htrans_a", 64'(o_htrans), 64'd2);
        step();
        bus_rr.HRESP = 1'b1;
        bus_rr.HREADY = 1'b0;
        check("t4_htrans_d", 64'(o_htrans), 64'd0);
        step();
        bus_rr.HREADY = 1'b1;
        check("t4_htrans_e", 64'(o_htrans), 64'd0);
        check("t4_no_early_resp", 64'(o_v0), 64'd0);
        step();
        bus_rr.HRESP = 1'b0;
        check("t4_rvalid", 64'(o_v0), 64'd1);
        check("t4_err", 64'(o_e0), 64'd1);
        check("t4_htrans_r", 64'(o_htrans), 64'd0);
        step();
        drain();

        // Misaligned halfword (m0) then misaligned word (m1)
        ns0 = nonseq_cnt;
        req(0, 1'b1, 1'b0, 32'h101, '0, 3'd1, 1'b0);
        wait_grant(g);
        check("t5_grant", 64'(g), 64'd0);
        push_exp(1'b0, '0, 1'b1);
        step();
        req(0, 1'b0, 1'b0, '0, '0, 3'd0, 1'b0);
        req(1, 1'b1, 1'b0, 32'h102, '0, 3'd2, 1'b0);
        #1;
        check("t5_m0_rvalid", 64'(o_v0), 64'd1);
        check("t5_m0_err", 64'(o_e0), 64'd1);
        check("t5_m1_ready", 64'(o_r1), 64'd1);
        push_exp(1'b1, '0, 1'b1);
        step();
        req(1, 1'b0, 1'b0, '0, '0, 3'd0, 1'b0);
        check("t5_m1_rvalid", 64'(o_v1), 64'd1);
        check("t5_m1_err", 64'(o_e1), 64'd1);
        step();
        step();
        check("t5_no_nonseq", 64'(nonseq_cnt - ns0), 64'd0);
        drain();

        // Reset during the data phase of an m0 read
        req(0, 1'b1, 1'b0, 32'h400, '0, 3'd2, 1'b1);
        wait_grant(g);
        check("t6_grant", 64'(g), 64'd0);
        step();
        req(0, 1'b0, 1'b0, '0, '0, 3'd0, 1'b0);
        #1;
        check("t6_htrans_a", 64'(o_htrans), 64'd2);
        check("t6_unsign", 64'(o_uns), 64'd1);
        step();
        bus_rr.HREADY = 1'b0;
        #1;
        check("t6_htrans_d", 64'(o_htrans), 64'd0);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_rst");
        step();
        step();
        rst = 1'b0;
        bus_rr.HREADY = 1'b1;
        bus_rr.HRDATA = 32'h0BAD_F00D;
        req(0, 1'b1, 1'b0, 32'h500, '0, 3'd2, 1'b0);
        req(1, 1'b1, 1'b0, 32'h600, '0, 3'd2, 1'b0);
        wait_grant(g);
        check("t6_tie_after_rst", 64'(g), 64'd0);
        push_exp(1'b0, 32'h0BAD_F00D, 1'b0);
        step();
        req(0, 1'b0, 1'b0, '0, '0, 3'd0, 1'b0);
        req(1, 1'b0, 1'b0, '0, '0, 3'd0, 1'b0);
        drain();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ahb_mem_arbiter.md
# ahb_mem_arbiter

Two-requester AHB-Lite bus arbiter and transfer sequencer for the memory subsystem. It shares one AHB-Lite manager port between the data requester (m0, the memory-stage load/store path) and the instruction-fetch requester (m1). It sequences each single transfer through the address and data phases, handles wait states and two-cycle ERROR responses, and returns a registered response to the owning requester. It sits between the pipeline request ports and the bus decoder/subordinates.

## Interface
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width
- FIXED_PRIO, 0, 0 = round-robin on contention; 1 = m0 always wins
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- mX_req_valid  in  1  request pending (X = 0 data, X = 1 fetch)
- mX_req_write  in  1  1 = write
- mX_req_addr  in  ADDR_WIDTH  byte address
- mX_req_wdata  in  DATA_WIDTH  write data
- mX_req_size  in  3  HSIZE encoding (0 byte, 1 half, 2 word)
- mX_req_unsign  in  1  unsigned-load flag
- mX_req_ready  out  1  request accepted this cycle
- mX_resp_valid  out  1  one-cycle response pulse
- mX_resp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
- mX_resp_err  out  1  error qualifier, valid with resp_valid
- HADDR  out  ADDR_WIDTH; HTRANS out 2; HWRITE out 1; HSIZE out 3; HBURST out 3; HPROT out 4; HWDATA out DATA_WIDTH
- HRDATA  in  DATA_WIDTH; HREADY  in  1; HRESP  in  1
- sub_unsign_o  out  1  unsign flag of the current transfer, to the subordinate

## Operation
- FSM states: IDLE, ADDR, DATA, ERR1. There is one outstanding transfer at most.
- IDLE:
  - Arbitrate among valid requests. On a tie, round-robin grants the requester not granted last; FIXED_PRIO=1 grants m0.
  - Pulse the winner's req_ready and capture its addr, wdata, size, write, unsign and the owner ID.
  - Misalignment is half with addr[0]=1, or word with addr[1:0]≠0. A misaligned request is accepted and not issued on the bus; the next state is IDLE, and resp_valid=1, resp_err=1 are issued next cycle.
  - An aligned request goes to ADDR.
- ADDR:
  - Outputs: HTRANS=NONSEQ (2'b10), HADDR/HWRITE/HSIZE from the capture, HBURST=3'b000.
  - HPROT=4'b0011 when the owner is m0 and 4'b0010 when the owner is m1.
  - HREADY=1 → DATA. HREADY=0 → hold all address-phase outputs.
- DATA:
  - HTRANS=IDLE (2'b00); HWDATA = captured wdata.
  - HREADY=0 with HRESP=0 → stay.
  - HREADY=1 with HRESP=0 → register the response (rdata=HRDATA for reads, 0 for writes; err=0) → IDLE.
  - HRESP=1 with HREADY=0 → ERR1.
- ERR1: wait for HREADY=1 (HRESP=1), then register an err=1 response with rdata=0 → IDLE.
- The last-grant pointer updates only on bus-issued or misaligned acceptances.
- sub_unsign_o holds the captured flag in ADDR, DATA and ERR1, and is 0 in IDLE.
- A requester must hold its req fields stable until req_ready. Dropping req_valid before req_ready is legal and withdraws the request.

## Timing
- Reset values: state=IDLE, HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HPROT=0, HWDATA=0, all req_ready=0, all resp_valid=0, rdata=0, err=0, sub_unsign_o=0. The last-grant pointer resets to m1, so m0 wins the first tie.
- Zero-wait aligned transfer:
  - Accept at cycle T, address phase at T+1, data phase at T+2, resp_valid at T+3.
  - A new acceptance is allowed at T+3 in the same cycle as resp_valid, giving a 3-cycle throughput.
- Each wait state adds one cycle. An ERROR response adds the ERR1 cycle.
- Misaligned request: accept at T, resp_valid=1 with err=1 at T+1, no bus activity.
- req_ready is combinational from IDLE and req_valid. Bus outputs and responses are registered.
- Reset asserted mid-transfer: all outputs go to reset values immediately, with no response to the owner.

## Test plan
- m0 aligned word read of 0x0000_0100 with HRDATA=0xDEAD_BEEF, zero wait. Required: m0_req_ready at T; NONSEQ, HADDR=0x100, HPROT=0011 at T+1; m0_resp_valid with rdata=0xDEADBEEF, err=0 at T+3.
- m1 write of 0x1234_5678 to 0x200 with HREADY low for 2 data-phase cycles. Required: HWDATA=0x12345678 held during the data phase; m1_resp_valid at T+5 with rdata=0.
- m0 and m1 valid every cycle with FIXED_PRIO=0 for 4 transfers. Required: grants m0, m1, m0, m1. Repeat with FIXED_PRIO=1. Required: m0 only while it stays valid.
- Two-cycle ERROR response (HRESP=1, HREADY=0, then HRESP=1, HREADY=1) on an m0 read. Required: HTRANS=IDLE throughout; m0_resp_err=1, rdata=0.
- m0 halfword at 0x101 and m1 word at 0x102. Required: each gets err=1 one cycle after acceptance; HTRANS never NONSEQ.
- rst_i asserted during DATA. Required: all outputs at reset values in the same cycle; the next tie after release grants m0.
